// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the blocks that drive it.
package alu_pkg;

    typedef enum logic [2:0] {
        FN_ADD  = 3'd0,
        FN_ADDC = 3'd1,
        FN_SUB  = 3'd2,
        FN_SUBC = 3'd3,
        FN_AND  = 3'd4,
        FN_OR   = 3'd5,
        FN_XOR  = 3'd6,
        FN_MASK = 3'd7
    } fn_e;

    // Function used for bytes above the LSB: arithmetic ops must chain carry/borrow.
    function automatic fn_e to_chain_fn(input fn_e fn);
        case (fn)
            FN_ADD, FN_ADDC: return FN_ADDC;
            FN_SUB, FN_SUBC: return FN_SUBC;
            default:         return fn;
        endcase
    endfunction

    function automatic logic is_logic(input fn_e fn);
        return (fn inside {FN_AND, FN_OR, FN_XOR, FN_MASK});
    endfunction

endpackage

// File: rtl/multibyte_alu_seq.sv
// Sequences an NBYTES-wide operation through the external 8-bit ALU, LSB first,
// chaining carry/borrow between bytes, with a start/busy/done handshake.
module multibyte_alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_fn,
    output logic                  alu_cin,
    input  logic [7:0]            alu_out,
    input  logic                  alu_c,
    input  logic                  alu_z
);

    localparam int unsigned   IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e        state, next_state;
    fn_e           op_q;
    logic          cin_q;
    logic [7:0]    opa_q [NBYTES];
    logic [7:0]    opb_q [NBYTES];
    logic [7:0]    acc_q [NBYTES];
    logic [IW-1:0] idx;
    logic          chain;
    logic          zacc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state and ALU drive; ALU pins are held at zero outside RUN.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_fn     = '0;
        alu_cin    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                alu_a  = opa_q[idx];
                alu_b  = opb_q[idx];
                alu_fn = (idx == '0) ? op_q : to_chain_fn(op_q);
                if (is_logic(op_q))
                    alu_cin = 1'b0;
                else if (idx == '0)
                    alu_cin = (op_q inside {FN_ADDC, FN_SUBC}) ? cin_q : 1'b0;
                else
                    alu_cin = chain;
                if (idx == LAST) next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand latch, per-byte capture and result publication.
    // Bytes collect in acc_q during RUN; result/carry/zero/done are registered
    // from DONE, so the visible result only changes together with the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= FN_ADD;
            cin_q  <= 1'b0;
            idx    <= '0;
            chain  <= 1'b0;
            zacc   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            for (int unsigned i = 0; i < NBYTES; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= fn_e'(op);
                        cin_q <= cin;
                        idx   <= '0;
                        chain <= 1'b0;
                        zacc  <= 1'b1;
                        for (int unsigned i = 0; i < NBYTES; i++) begin
                            opa_q[i] <= opa[8*i +: 8];
                            opb_q[i] <= opb[8*i +: 8];
                        end
                    end
                end
                S_RUN: begin
                    acc_q[idx] <= alu_out;
                    chain      <= alu_c;
                    zacc       <= zacc & alu_z;
                    idx        <= (idx == LAST) ? '0 : idx + IW'(1);
                end
                S_DONE: begin
                    done  <= 1'b1;
                    carry <= is_logic(op_q) ? 1'b0 : chain;
                    zero  <= zacc;
                    for (int unsigned i = 0; i < NBYTES; i++)
                        result[8*i +: 8] <= acc_q[i];
                end
                default: ;
            endcase
        end
    end

endmodule
